// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the shared-ALU controller and its core.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLL   = 3'b101;
  localparam logic [2:0] OP_SRL   = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between two requesters, the response consumer and the shared-ALU controller.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, busy
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: eight operations, carry/borrow for ADD/SUB, zero flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] data,
  output logic             carry,
  output logic             zero
);

  always_comb begin
    data  = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:   {carry, data} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        data  = a - b;
        carry = (a < b);
      end
      OP_AND:   data = a & b;
      OP_OR:    data = a | b;
      OP_XOR:   data = a ^ b;
      // Shift by the full b value: any amount >= WIDTH shifts everything out.
      OP_SLL:   data = a << b;
      OP_SRL:   data = a >> b;
      OP_PASSA: data = a;
      default:  data = '0;
    endcase
  end

  assign zero = (data == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter + IDLE/EXEC/RESP FSM sharing one alu_core between two requesters.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_ctrl_if.slave       bus
);

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;

  logic             grant0, grant1, hs;
  logic [WIDTH-1:0] core_data;
  logic             core_carry, core_zero;

  // Pointer names the requester that wins a tie; a lone valid always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
      grant1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
    end
  end

  assign hs             = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .data  (core_data),
    .carry (core_carry),
    .zero  (core_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_zero  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            op_q  <= grant1 ? bus.req1_op : bus.req0_op;
            a_q   <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q   <= grant1 ? bus.req1_b  : bus.req0_b;
            id_q  <= grant1;
            ptr_q <= ~grant1;
          end
        end
        ST_EXEC: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_id    <= id_q;
          bus.rsp_data  <= core_data;
          bus.rsp_carry <= core_carry;
          bus.rsp_zero  <= core_zero;
        end
        ST_RESP: begin
          // Data registers keep their last value after the response is taken.
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table plus arbitration, backpressure and reset sequences.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } vec_t;

  vec_t vecs[14];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Returns in the cycle a ready is seen (still before the accepting edge).
  task automatic wait_grant(output logic gid);
    bit ok;
    ok  = 1'b0;
    gid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("grant_timeout");
    else begin
      chk("one_ready", {bus.req0_ready, bus.req1_ready} == 2'b11, 0);
      gid = bus.req1_ready;
    end
  endtask

  task automatic rsp_check(input string tag, input logic id, input logic [7:0] data,
                           input logic carry, input logic zero);
    chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_id"},    bus.rsp_id,    id);
    chk({tag, "_data"},  bus.rsp_data,  data);
    chk({tag, "_carry"}, bus.rsp_carry, carry);
    chk({tag, "_zero"},  bus.rsp_zero,  zero);
  endtask

  task automatic run_one(input string tag, input vec_t v);
    logic gid;
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    wait_grant(gid);
    chk({tag, "_grant"}, gid, v.id);
    @(negedge clk);
    set_req(v.id, 1'b0, v.op, v.a, v.b);
    chk({tag, "_exec_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_exec_busy"},  bus.busy, 1'b1);
    @(negedge clk);
    rsp_check(tag, v.id, v.data, v.carry, v.zero);
    @(negedge clk);
    chk({tag, "_done_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_done_busy"},  bus.busy, 1'b0);
  endtask

  // One operation of a sequence where both requesters keep valid high.
  task automatic tie_step(input string tag, input logic exp_id, input logic [7:0] data,
                          input logic carry, input logic zero);
    logic gid;
    wait_grant(gid);
    chk({tag, "_grant"}, gid, exp_id);
    @(negedge clk);
    @(negedge clk);
    rsp_check(tag, exp_id, data, carry, zero);
    @(negedge clk);
  endtask

  initial begin
    logic gid;
    bit   ok;

    vecs[0]  = '{1'b0, OP_ADD,   8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB,   8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, OP_XOR,   8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, OP_SLL,   8'h81, 8'h01, 8'h02, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_SRL,   8'h81, 8'h07, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, OP_SLL,   8'h81, 8'h08, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, OP_PASSA, 8'h3C, 8'h55, 8'h3C, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_OR,    8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b0, OP_SUB,   8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_SRL,   8'h80, 8'h08, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{1'b0, OP_SLL,   8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[13] = '{1'b1, OP_ADD,   8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

    set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    bus.rsp_ready = 1'b1;

    // Reset state, then idle with no requests.
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_rsp_carry", bus.rsp_carry, 1'b0);
    chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
      chk("idle_ready0", bus.req0_ready, 1'b0);
      chk("idle_ready1", bus.req1_ready, 1'b0);
    end

    // Both valid out of reset: 0 wins first, then alternation while both stay valid.
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, OP_SUB, 8'h05, 8'h07);
    set_req(1'b1, 1'b1, OP_XOR, 8'hAA, 8'hAA);
    @(negedge clk);
    rst_n = 1'b1;
    tie_step("tie_a0", 1'b0, 8'hFE, 1'b1, 1'b0);
    tie_step("tie_a1", 1'b1, 8'h00, 1'b0, 1'b1);
    tie_step("tie_a2", 1'b0, 8'hFE, 1'b1, 1'b0);
    tie_step("tie_a3", 1'b1, 8'h00, 1'b0, 1'b1);
    set_req(1'b0, 1'b0, OP_SUB, 8'h05, 8'h07);
    set_req(1'b1, 1'b0, OP_XOR, 8'hAA, 8'hAA);

    for (int i = 0; i < 14; i++) run_one($sformatf("vec%0d", i), vecs[i]);

    // After req0 finishes, a tie goes to req1 first.
    run_one("pre_tie", vecs[0]);
    set_req(1'b0, 1'b1, OP_SUB, 8'h05, 8'h07);
    set_req(1'b1, 1'b1, OP_XOR, 8'hAA, 8'hAA);
    tie_step("tie_b0", 1'b1, 8'h00, 1'b0, 1'b1);
    tie_step("tie_b1", 1'b0, 8'hFE, 1'b1, 1'b0);
    set_req(1'b0, 1'b0, OP_SUB, 8'h05, 8'h07);
    set_req(1'b1, 1'b0, OP_XOR, 8'hAA, 8'hAA);

    // Response backpressure with req1 waiting.
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, OP_ADD, 8'hF0, 8'h20);
    wait_grant(gid);
    chk("bp_grant", gid, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_ADD, 8'hF0, 8'h20);
    set_req(1'b1, 1'b1, OP_AND, 8'hF0, 8'h3C);
    #1;
    chk("bp_exec_ready1", bus.req1_ready, 1'b0);
    @(negedge clk);
    rsp_check("bp_rsp", 1'b0, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.rsp_valid, 1'b1);
      chk("bp_hold_data", bus.rsp_data, 8'h10);
      chk("bp_hold_carry", bus.rsp_carry, 1'b1);
      chk("bp_hold_id", bus.rsp_id, 1'b0);
      chk("bp_hold_busy", bus.busy, 1'b1);
      chk("bp_hold_ready0", bus.req0_ready, 1'b0);
      chk("bp_hold_ready1", bus.req1_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", bus.rsp_valid, 1'b0);
    chk("bp_rel_data_kept", bus.rsp_data, 8'h10);
    chk("bp_rel_ready1", bus.req1_ready, 1'b1);
    @(negedge clk);
    set_req(1'b1, 1'b0, OP_AND, 8'hF0, 8'h3C);
    @(negedge clk);
    rsp_check("bp_next", 1'b1, 8'h30, 1'b0, 1'b0);
    @(negedge clk);

    // Reset during EXEC drops the operation and restores the pointer.
    set_req(1'b0, 1'b1, OP_ADD, 8'h01, 8'h01);
    wait_grant(gid);
    chk("mid_grant", gid, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01);
    chk("mid_exec_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_data", bus.rsp_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_post_valid", bus.rsp_valid, 1'b0);
      chk("mid_post_busy", bus.busy, 1'b0);
    end
    set_req(1'b0, 1'b1, OP_ADD, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, OP_OR, 8'h0F, 8'hF0);
    tie_step("mid_tie", 1'b0, 8'h02, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01);
    set_req(1'b1, 1'b0, OP_OR, 8'h0F, 8'hF0);

    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy) ok = 1'b1;
    end
    chk("final_quiet", ok, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that shares one combinational ALU core between two requesters.
- Round-robin arbitration; operands latched on the request handshake.
- Result, carry and zero flags returned on a single response channel tagged with the requester id.
- Sits between the two instruction/stimulus sources and the ALU datapath. It is the only block that drives the ALU operands.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2, power of two).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  requester 0 opcode
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_op  in  3  requester 1 opcode
- req1_a  in  WIDTH  requester 1 operand A
- req1_b  in  WIDTH  requester 1 operand B
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  ALU result
- rsp_carry  out  1  carry (ADD) or borrow (SUB); 0 for all other ops
- rsp_zero  out  1  rsp_data == 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; priority pointer = 0 (requester 0 wins the first tie).
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_carry = 0, rsp_zero = 0, busy = 0.
  - Latched op/a/b = 0. reqX_ready is combinational and therefore 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. With only one valid, that requester is granted; with both valid, the requester selected by the pointer is granted.
  - reqX_ready = 1 only for the granted requester; at most one ready is high per cycle.
  - On handshake (valid & ready): latch op, a, b and the id; pointer <= ~id; next state EXEC.
  - With no valid: stay in IDLE.
- EXEC: the ALU core evaluates the latched operands. Register result, carry and zero into the rsp_* outputs; rsp_valid <= 1; next state RESP.
- RESP:
  - rsp_* held stable while rsp_valid = 1 and rsp_ready = 0.
  - On rsp_ready: rsp_valid <= 0 and next state IDLE. The rsp_* data registers keep their last value.
- Latency: handshake in cycle N -> rsp_valid high from cycle N+2. Minimum 3 cycles per operation; no new grant before RESP completes.
- Requester rules: valid must stay high with stable op/a/b until ready. Deasserting valid without a handshake is allowed and has no effect.
- Opcodes:
  - 000 ADD: {carry, data} = a + b, computed at WIDTH+1 bits.
  - 001 SUB: data = a - b mod 2^WIDTH; carry = (a < b) unsigned borrow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: data = a << b.
  - 110 SRL: data = a >> b (logical).
  - 111 PASSA: data = a.
- Shift amount is the full b value; b >= WIDTH gives data = 0.
- Overflow wraps modulo 2^WIDTH.
- Simultaneous events:
  - Requests arriving during EXEC/RESP see ready = 0 and wait.
  - A requester that just finished and re-requests loses a tie to the other (pointer flipped).
- Reset mid-operation: in-flight operation dropped, no response issued, pointer back to 0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_PASSA (3-bit);
  - FSM state encoding ST_IDLE/ST_EXEC/ST_RESP (2-bit).
- One sub-module, alu_core: purely combinational; inputs op, a, b; outputs data, carry, zero; parameter WIDTH.
- alu_share_ctrl contains the arbiter, FSM and registers.

Test Plan:
- Reset release, no requests -> busy = 0, rsp_valid = 0, both ready = 0 for 10 cycles.
- req0 ADD a = 8'hF0, b = 8'h20, rsp_ready = 1:
  - req0_ready high in cycle N;
  - rsp_valid in N+2 with rsp_id = 0, rsp_data = 8'h10, rsp_carry = 1, rsp_zero = 0.
- req0 and req1 both valid from reset (req0 SUB 5-7, req1 XOR 8'hAA^8'hAA):
  - first response id 0, data 8'hFE, carry 1;
  - second response id 1, data 8'h00, zero 1.
  - Repeat with both valid: grants alternate 1, 0.
- Response backpressure: rsp_ready = 0 for 5 cycles in RESP:
  - rsp_* stable, busy = 1, both ready = 0;
  - rsp_ready = 1 -> rsp_valid falls next cycle and IDLE grants a waiting request.
- Shifts:
  - SLL a = 8'h81, b = 1 -> 8'h02.
  - SRL a = 8'h81, b = 7 -> 8'h01.
  - SLL b = 8 -> 8'h00 with zero = 1.
  - PASSA a = 8'h3C -> 8'h3C, carry 0.
- Assert rst_n low during EXEC -> rsp_valid = 0 immediately, no response after release; the next tie is granted to req0.
